pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB latches).
- Detects load-use hazards, applies taken-branch flushes and freezes the pipeline while a data-memory access waits on a ready handshake.
- Drives enable/bubble controls for every pipeline latch and the PC, and keeps saturating performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, taken-branch
// flush, data-memory wait freeze with timeout to HALT, and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             branch_taken,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             exmem_bubble,
    output logic             memwb_bubble,
    output logic             dmem_req,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              stall_inc, flush_inc;
    logic              mem_access, load_use;

    assign mem_access = exmem_memread | exmem_memwrite;
    assign load_use   = idex_memread && (idex_rt != 5'd0) &&
                        ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        dmem_req     = mem_access;
        halted       = 1'b0;
        case (state)
            RUN: begin
                if (mem_access && !dmem_ready) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    stall_inc    = 1'b1;
                    wait_nxt     = WAIT_W'(1);
                    state_nxt    = (MEM_TIMEOUT == 1) ? HALT : MEM_WAIT;
                end else if (branch_taken) begin
                    // Branch alongside a memory op is illegal: the flush is dropped.
                    if (!mem_access) begin
                        ifid_flush   = 1'b1;
                        idex_bubble  = 1'b1;
                        exmem_bubble = 1'b1;
                        flush_inc    = 1'b1;
                    end
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    stall_inc    = 1'b1;
                    wait_nxt     = wait_cnt + 1'b1;
                    // This cycle brings the count of frozen cycles to MEM_TIMEOUT.
                    if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) state_nxt = HALT;
                end else begin
                    wait_nxt  = '0;
                    state_nxt = RUN;
                end
            end
            HALT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                dmem_req = 1'b0;
                halted   = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (CNT_W=4, MEM_TIMEOUT=4): expected control
// vectors are queued as stimulus is applied and popped when the DUT outputs are sampled.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble, memwb_bubble, dmem_req, halted}
    localparam logic [9:0] O_DEF    = 10'b1101010000;
    localparam logic [9:0] O_REQ    = 10'b1101010010;
    localparam logic [9:0] O_LU     = 10'b0001110000;
    localparam logic [9:0] O_FREEZE = 10'b0000000110;
    localparam logic [9:0] O_BR     = 10'b1111111000;
    localparam logic [9:0] O_HALT   = 10'b0000000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic idex_memread = 1'b0, exmem_memread = 1'b0, exmem_memwrite = 1'b0;
    logic branch_taken = 1'b0, dmem_ready = 1'b0;
    logic [4:0] idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;
    logic exmem_bubble, memwb_bubble, dmem_req, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [9:0] outs;

    int total = 0;
    int bad = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
                   exmem_bubble, memwb_bubble, dmem_req, halted};

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .branch_taken(branch_taken), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .exmem_bubble(exmem_bubble),
        .memwb_bubble(memwb_bubble), .dmem_req(dmem_req), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic clear_inputs();
        idex_memread = 0; exmem_memread = 0; exmem_memwrite = 0;
        branch_taken = 0; dmem_ready = 0;
        idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        #2;
        rst_n = 1;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        exp_q.push_back(O_DEF);
        #3;
        e = exp_q.pop_front();
        total++;
        if (outs !== e) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, e); end
        total++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_inputs();
            idex_memread = 1; ifid_rs = 5;
            idex_rt = (i == 0) ? 5'd5 : (i == 1) ? 5'd0 : 5'd7;
            if (i == 2) ifid_rt = 7;
            exp_q.push_back((i == 1) ? O_DEF : O_LU);
            if (i != 1) exp_stall++;
            #1;
            e = exp_q.pop_front();
            total++;
            if (outs !== e) begin bad++; $display("FAIL load_use[%0d] got=%b exp=%b", i, outs, e); end
            @(posedge clk); #1;
            total++;
            if (stall_cnt !== CNT_W'(exp_stall)) begin
                bad++; $display("FAIL load_use_cnt[%0d] got=%0d exp=%0d", i, stall_cnt, exp_stall);
            end
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_inputs();
            exmem_memread = (i < 4);
            dmem_ready = (i >= 3);
            // Hazard inputs must be ignored during the wait
            idex_memread = 1; idex_rt = 3; ifid_rs = 3;
            exp_q.push_back((i < 3) ? O_FREEZE : (i == 3) ? O_REQ : O_LU);
            if (i != 3) exp_stall++;
            #1;
            e = exp_q.pop_front();
            total++;
            if (outs !== e) begin bad++; $display("FAIL mem_wait[%0d] got=%b exp=%b", i, outs, e); end
        end
        @(posedge clk); #1;
        total++;
        if (stall_cnt !== CNT_W'(exp_stall)) begin
            bad++; $display("FAIL mem_wait_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_zero_wait_store();
        do_reset();
        @(negedge clk);
        clear_inputs();
        exmem_memwrite = 1; dmem_ready = 1;
        exp_q.push_back(O_REQ);
        #1;
        e = exp_q.pop_front();
        total++;
        if (outs !== e) begin bad++; $display("FAIL zero_wait got=%b exp=%b", outs, e); end
        @(posedge clk); #1;
        total++;
        if (stall_cnt !== 4'd0) begin bad++; $display("FAIL zero_wait_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            clear_inputs();
            branch_taken = 1;
            idex_memread = 1; idex_rt = 9; ifid_rt = 9;
            // Second cycle: branch with a pending load is illegal, the wait wins
            exmem_memread = (i == 1);
            exp_q.push_back((i == 0) ? O_BR : O_FREEZE);
            if (i == 0) exp_flush++; else exp_stall++;
            #1;
            e = exp_q.pop_front();
            total++;
            if (outs !== e) begin bad++; $display("FAIL branch[%0d] got=%b exp=%b", i, outs, e); end
            @(posedge clk); #1;
            total++;
            if (flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall)) begin
                bad++; $display("FAIL branch_cnt[%0d] got=%0d/%0d exp=%0d/%0d",
                                i, flush_cnt, stall_cnt, exp_flush, exp_stall);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clear_inputs();
            exmem_memread = 1;
            dmem_ready = (i == 6);
            branch_taken = (i == 5);
            exp_q.push_back((i < TMO) ? O_FREEZE : O_HALT);
            if (i < TMO) exp_stall++;
            #1;
            e = exp_q.pop_front();
            total++;
            if (outs !== e) begin bad++; $display("FAIL timeout[%0d] got=%b exp=%b", i, outs, e); end
        end
        @(posedge clk); #1;
        total++;
        if (stall_cnt !== CNT_W'(exp_stall)) begin
            bad++; $display("FAIL timeout_cnt got=%0d exp=%0d", stall_cnt, exp_stall);
        end
        #2;
        clear_inputs();
        rst_n = 0;
        exp_q.push_back(O_DEF);
        #1;
        e = exp_q.pop_front();
        total++;
        if (outs !== e || stall_cnt !== 4'd0) begin
            bad++; $display("FAIL halt_reset got=%b/%0d exp=%b/0", outs, stall_cnt, e);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        clear_inputs();
        idex_memread = 1; idex_rt = 4; ifid_rs = 4;
        for (int i = 0; i < 20; i++) begin
            exp_stall = (exp_stall < 15) ? exp_stall + 1 : 15;
            @(posedge clk);
        end
        #1;
        total++;
        if (stall_cnt !== CNT_W'(exp_stall)) begin
            bad++; $display("FAIL saturation got=%0d exp=%0d", stall_cnt, exp_stall);
        end
        @(negedge clk);
        clear_inputs();
        branch_taken = 1;
        for (int i = 0; i < 18; i++) begin
            exp_flush = (exp_flush < 15) ? exp_flush + 1 : 15;
            @(posedge clk);
        end
        #1;
        total++;
        if (flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== 4'd15) begin
            bad++; $display("FAIL flush_saturation got=%0d/%0d exp=%0d/15", flush_cnt, stall_cnt, exp_flush);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_zero_wait_store();
        test_branch();
        test_timeout();
        test_saturation();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL queue_leftover got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
